// File: rtl/vga_sync_monitor.sv
`timescale 1ns/1ps
// Receive-side VGA timing monitor: recovers pixel coordinates from sampled syncs,
// measures line/frame timing, locks, and probes one pixel. Define VGA_MON_CRC_EN for frame_sig.
module vga_sync_monitor #(
    parameter int H_EXPECT    = 800,
    parameter int V_EXPECT    = 525,
    parameter int H_SYNC_POS  = 656,
    parameter int V_SYNC_POS  = 513,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2,
    parameter bit SYNC_ACTIVE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_tick,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    input  logic [9:0]  probe_x,
    input  logic [9:0]  probe_y,
    input  logic        err_clr,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic        rx_active,
    output logic [9:0]  h_total,
    output logic [9:0]  v_total,
    output logic        locked,
    output logic        err,
    output logic        frame_done,
    output logic [11:0] probe_rgb,
    output logic        probe_valid
`ifdef VGA_MON_CRC_EN
    ,
    output logic [15:0] frame_sig
`endif
);

    localparam logic [9:0] LP_H_EXP  = 10'(H_EXPECT);
    localparam logic [9:0] LP_V_EXP  = 10'(V_EXPECT);
    localparam logic [9:0] LP_H_LAST = 10'(H_EXPECT - 1);
    localparam logic [9:0] LP_V_LAST = 10'(V_EXPECT - 1);
    localparam logic [9:0] LP_H_SYNC = 10'(H_SYNC_POS);
    localparam logic [9:0] LP_V_SYNC = 10'(V_SYNC_POS);
    localparam logic [9:0] LP_H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] LP_V_ACT  = 10'(V_ACTIVE);
    localparam logic [3:0] LP_LOCK   = 4'(LOCK_FRAMES);
    localparam logic [9:0] LP_SAT    = 10'h3FF;

    typedef enum logic [1:0] {ST_IDLE, ST_ACQUIRE, ST_LOCKED} state_t;

    function automatic logic [9:0] sat_len(input logic [10:0] v);
        return v[10] ? LP_SAT : v[9:0];
    endfunction

    function automatic logic [9:0] inc_sat(input logic [9:0] v);
        return (v == LP_SAT) ? v : v + 10'd1;
    endfunction

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_good;
    logic [3:0]  w_good_nxt;
    logic        w_err_set;
    logic        r_hs_prev;
    logic        r_vs_prev;
    logic [9:0]  r_h_cnt;
    logic [9:0]  r_line_cnt;
    logic [9:0]  r_rx_x;
    logic [9:0]  r_rx_y;
    logic        r_rx_active;
    logic [9:0]  r_h_total;
    logic [9:0]  r_v_total;
    logic        r_h_armed;
    logic        r_bad;
    logic        r_err;
    logic        r_frame_done;
    logic [11:0] r_probe_rgb;
    logic        r_probe_valid;

    logic        w_hs_act;
    logic        w_vs_act;
    logic        w_hs_edge;
    logic        w_vs_edge;
    logic [10:0] w_h_len;
    logic        w_line_bad;
    logic        w_sync_loss;
    logic        w_frame_ok;
    logic        w_x_wrap;
    logic [9:0]  w_x_nxt;
    logic [9:0]  w_y_nxt;
    logic        w_act_nxt;
    logic        w_probe_hit;

    assign w_hs_act    = (hsync == SYNC_ACTIVE);
    assign w_vs_act    = (vsync == SYNC_ACTIVE);
    assign w_hs_edge   = p_tick && w_hs_act && !r_hs_prev;
    assign w_vs_edge   = p_tick && w_vs_act && !r_vs_prev;
    assign w_h_len     = {1'b0, r_h_cnt} + 11'd1;
    // The first line after (re)acquisition starts at an arbitrary point, so it is not judged.
    assign w_line_bad  = w_hs_edge && r_h_armed && (w_h_len != 11'(H_EXPECT));
    assign w_sync_loss = p_tick && !w_hs_edge && (r_h_cnt == LP_SAT - 10'd1);
    assign w_frame_ok  = !r_bad && (r_line_cnt == LP_V_EXP);

    // Coordinates of the sample being taken on this tick.
    always_comb begin
        w_x_wrap = 1'b0;
        w_x_nxt  = r_rx_x + 10'd1;
        w_y_nxt  = r_rx_y;
        if (w_hs_edge) begin
            w_x_nxt = LP_H_SYNC;
        end else if (r_rx_x == LP_H_LAST) begin
            w_x_nxt  = '0;
            w_x_wrap = 1'b1;
        end
        if (w_vs_edge) begin
            w_y_nxt = LP_V_SYNC;
        end else if (w_x_wrap) begin
            w_y_nxt = (r_rx_y == LP_V_LAST) ? '0 : r_rx_y + 10'd1;
        end
    end

    assign w_act_nxt   = (w_x_nxt < LP_H_ACT) && (w_y_nxt < LP_V_ACT);
    assign w_probe_hit = p_tick && (r_state == ST_LOCKED) &&
                         (probe_x < LP_H_EXP) && (probe_y < LP_V_EXP) &&
                         (w_x_nxt == probe_x) && (w_y_nxt == probe_y);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good;
        w_err_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_vs_edge) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                end
            end
            ST_ACQUIRE: begin
                if (w_vs_edge) begin
                    if (w_frame_ok) begin
                        w_good_nxt = r_good + 4'd1;
                        if (w_good_nxt == LP_LOCK) w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_sync_loss) begin
                    w_state_nxt = ST_IDLE;
                    w_good_nxt  = '0;
                    w_err_set   = 1'b1;
                end else if (w_line_bad || (w_vs_edge && !w_frame_ok)) begin
                    w_state_nxt = ST_ACQUIRE;
                    w_good_nxt  = '0;
                    w_err_set   = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        locked = (r_state == ST_LOCKED);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_good        <= '0;
            r_hs_prev     <= 1'b0;
            r_vs_prev     <= 1'b0;
            r_h_cnt       <= '0;
            r_line_cnt    <= '0;
            r_rx_x        <= '0;
            r_rx_y        <= '0;
            r_rx_active   <= 1'b0;
            r_h_total     <= '0;
            r_v_total     <= '0;
            r_h_armed     <= 1'b0;
            r_bad         <= 1'b0;
            r_err         <= 1'b0;
            r_frame_done  <= 1'b0;
            r_probe_rgb   <= '0;
            r_probe_valid <= 1'b0;
        end else begin
            r_frame_done  <= w_vs_edge;
            r_probe_valid <= w_probe_hit;
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
            if (p_tick) begin
                r_hs_prev   <= w_hs_act;
                r_vs_prev   <= w_vs_act;
                r_rx_x      <= w_x_nxt;
                r_rx_y      <= w_y_nxt;
                r_rx_active <= w_act_nxt;
                r_good      <= w_good_nxt;
                if (w_hs_edge) begin
                    r_h_cnt   <= '0;
                    r_h_total <= sat_len(w_h_len);
                end else begin
                    r_h_cnt <= inc_sat(r_h_cnt);
                end
                if (r_state == ST_LOCKED && w_sync_loss) begin
                    r_h_armed <= 1'b0;
                end else if (w_hs_edge) begin
                    r_h_armed <= 1'b1;
                end
                // An hsync edge coinciding with the vsync edge belongs to the new frame.
                if (w_vs_edge) begin
                    r_v_total  <= r_line_cnt;
                    r_line_cnt <= {9'd0, w_hs_edge};
                    r_bad      <= w_line_bad;
                end else begin
                    if (w_hs_edge) r_line_cnt <= inc_sat(r_line_cnt);
                    r_bad <= r_bad | w_line_bad;
                end
                if (w_probe_hit) r_probe_rgb <= rgb;
            end
        end
    end

    assign rx_x        = r_rx_x;
    assign rx_y        = r_rx_y;
    assign rx_active   = r_rx_active;
    assign h_total     = r_h_total;
    assign v_total     = r_v_total;
    assign err         = r_err;
    assign frame_done  = r_frame_done;
    assign probe_rgb   = r_probe_rgb;
    assign probe_valid = r_probe_valid;

`ifdef VGA_MON_CRC_EN
    logic [15:0] r_sig;
    logic [15:0] r_frame_sig;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sig       <= '0;
            r_frame_sig <= '0;
        end else if (p_tick) begin
            if (w_vs_edge) begin
                r_frame_sig <= r_sig;
                r_sig       <= '0;
            end else if (w_act_nxt) begin
                r_sig <= {r_sig[14:0], r_sig[15]} ^ {4'b0, rgb};
            end
        end
    end

    assign frame_sig = r_frame_sig;
`else
    // Frame signature logic is not built in this configuration.
`endif

endmodule

// File: tb/tb_vga_sync_monitor.sv
`timescale 1ns/1ps
// Directed bench for vga_sync_monitor: a shrunken-timing VGA generator is looped back
// into the monitor (40 ticks/line, 20 lines/frame) to keep runs short.
module tb_vga_sync_monitor;

    localparam int HE = 40;
    localparam int VE = 20;
    localparam int HS = 30;
    localparam int VS = 17;
    localparam int HA = 24;
    localparam int VA = 12;

    logic        clk = 1'b0;
    logic        reset;
    logic        p_tick;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;
    logic [9:0]  probe_x;
    logic [9:0]  probe_y;
    logic        err_clr;
    logic [9:0]  rx_x;
    logic [9:0]  rx_y;
    logic        rx_active;
    logic [9:0]  h_total;
    logic [9:0]  v_total;
    logic        locked;
    logic        err;
    logic        frame_done;
    logic [11:0] probe_rgb;
    logic        probe_valid;
`ifdef VGA_MON_CRC_EN
    logic [15:0] frame_sig;
`endif

    vga_sync_monitor #(
        .H_EXPECT(HE), .V_EXPECT(VE), .H_SYNC_POS(HS), .V_SYNC_POS(VS),
        .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2), .SYNC_ACTIVE(1'b1)
    ) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
        .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active), .h_total(h_total),
        .v_total(v_total), .locked(locked), .err(err), .frame_done(frame_done),
        .probe_rgb(probe_rgb), .probe_valid(probe_valid)
`ifdef VGA_MON_CRC_EN
        , .frame_sig(frame_sig)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int fd_cnt = 0;
    int pv_cnt = 0;
    int coord_err = 0;
    int tick_no = 0;
    int last_hs_tick = 0;
    int g_x = 0;
    int g_y = 0;
    int g_mode = 0;
    int s_x = 0;
    int s_y = 0;
    bit g_stretch = 1'b0;
    bit g_kill = 1'b0;
    bit g_clr = 1'b0;
    bit g_hs_prev = 1'b0;
    bit chk_coord = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pix_rgb(input int x, input int y);
        logic [9:0] xl;
        logic [9:0] yl;
        xl = x[9:0];
        yl = y[9:0];
        case (g_mode)
            0:       return {xl[3:0], yl[3:0], 4'hA};
            1:       return (x == HA - 1 && y == VA - 1) ? 12'h001 : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic count_pulses();
        if (frame_done === 1'b1) fd_cnt++;
        if (probe_valid === 1'b1) pv_cnt++;
    endtask

    // One pixel tick: drive a sample, let it be taken, then advance the generator.
    task automatic pix_tick();
        logic hs_d;
        logic vs_d;
        hs_d = (g_x >= HS && g_x < HS + 4) && !g_kill;
        vs_d = (g_y >= VS && g_y < VS + 2) && !g_kill;
        @(negedge clk);
        hsync   = hs_d;
        vsync   = vs_d;
        rgb     = pix_rgb(g_x, g_y);
        err_clr = g_clr;
        p_tick  = 1'b1;
        if (hs_d && !g_hs_prev) last_hs_tick = tick_no;
        g_hs_prev = hs_d;
        s_x = g_x;
        s_y = g_y;
        @(negedge clk);
        p_tick  = 1'b0;
        err_clr = 1'b0;
        count_pulses();
        if (chk_coord && (int'(rx_x) != s_x || int'(rx_y) != s_y ||
                          rx_active !== (s_x < HA && s_y < VA))) coord_err++;
        @(negedge clk);
        count_pulses();
        @(negedge clk);
        count_pulses();
        if (g_stretch && g_x == 5) begin
            g_stretch = 1'b0;
        end else if (g_x == HE - 1) begin
            g_x = 0;
            g_y = (g_y == VE - 1) ? 0 : g_y + 1;
        end else begin
            g_x++;
        end
        tick_no++;
    endtask

    task automatic run_frames(input int n, input string tag);
        int start;
        int guard;
        start = fd_cnt;
        guard = 0;
        while ((fd_cnt - start) < n && guard < 900 * n) begin
            pix_tick();
            guard++;
        end
        check({tag, "_frames"}, fd_cnt - start, n);
    endtask

    task automatic wait_locked(input logic val, input int budget, input string tag);
        int guard;
        guard = 0;
        while (locked !== val && guard < budget) begin
            pix_tick();
            guard++;
        end
        check({tag, "_locked"}, 32'(locked), 32'(val));
    endtask

    initial begin
        #950us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        p_tick  = 1'b0;
        hsync   = 1'b0;
        vsync   = 1'b0;
        rgb     = '0;
        probe_x = '0;
        probe_y = '0;
        err_clr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx_x", 32'(rx_x), 0);
        check("rst_rx_y", 32'(rx_y), 0);
        check("rst_rx_active", 32'(rx_active), 0);
        check("rst_locked", 32'(locked), 0);
        check("rst_err", 32'(err), 0);
        check("rst_h_total", 32'(h_total), 0);
        check("rst_v_total", 32'(v_total), 0);
        check("rst_probe_rgb", 32'(probe_rgb), 0);
        check("rst_pulses", 32'({frame_done, probe_valid}), 0);
        reset = 1'b0;

        // Acquisition: IDLE start plus two good frames.
        run_frames(2, "acq_a");
        check("acq_not_yet", 32'(locked), 0);
        run_frames(1, "acq_b");
        check("acq_locked", 32'(locked), 1);
        check("acq_h_total", 32'(h_total), HE);
        check("acq_v_total", 32'(v_total), VE);
        check("acq_err", 32'(err), 0);
        check("acq_rx_y", 32'(rx_y), VS);
        check("acq_rx_x", 32'(rx_x), 0);

        // Probe at origin and at last visible pixel, one capture per frame.
        chk_coord = 1'b1;
        probe_x = 10'd0;
        probe_y = 10'd0;
        pv_cnt = 0;
        run_frames(1, "probe0");
        check("probe0_rgb", 32'(probe_rgb), 32'h00A);
        check("probe0_pulses", pv_cnt, 1);
        probe_x = 10'(HA - 1);
        probe_y = 10'(VA - 1);
        pv_cnt = 0;
        run_frames(1, "probe1");
        check("probe1_rgb", 32'(probe_rgb), 32'h7BA);
        check("probe1_pulses", pv_cnt, 1);
        probe_x = 10'(HE);
        probe_y = 10'd0;
        pv_cnt = 0;
        run_frames(1, "probe_oob");
        check("probe_oob_pulses", pv_cnt, 0);
        check("probe_oob_hold", 32'(probe_rgb), 32'h7BA);
        chk_coord = 1'b0;
        check("coord_track", coord_err, 0);

        // Stretched line while locked; err_clr coincides with the failing tick.
        g_stretch = 1'b1;
        g_clr = 1'b1;
        wait_locked(1'b0, 100, "stretch");
        g_clr = 1'b0;
        check("stretch_err_set_wins", 32'(err), 1);
        check("stretch_at_hsync", s_x, HS);
        check("stretch_h_total", 32'(h_total), HE + 1);
        run_frames(2, "stretch_relock_a");
        check("stretch_still_unlocked", 32'(locked), 0);
        run_frames(1, "stretch_relock_b");
        check("stretch_relocked", 32'(locked), 1);
        check("stretch_err_sticky", 32'(err), 1);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("err_cleared", 32'(err), 0);

        // Sync loss: syncs held inactive until h_cnt saturates.
        g_kill = 1'b1;
        wait_locked(1'b0, 1200, "loss");
        check("loss_latency", (tick_no - 1) - last_hs_tick, 1023);
        check("loss_err", 32'(err), 1);
        g_kill = 1'b0;
        wait_locked(1'b1, 4000, "loss_relock");
        check("loss_relock_h_total", 32'(h_total), HE);

        // Asynchronous reset in the middle of a line.
        begin
            int guard;
            guard = 0;
            while (!(g_y == 5 && g_x == 10) && guard < 900) begin
                pix_tick();
                guard++;
            end
            check("reset_pos_reached", guard < 900, 1);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid_rst_locked", 32'(locked), 0);
        check("mid_rst_err", 32'(err), 0);
        check("mid_rst_rx_x", 32'(rx_x), 0);
        check("mid_rst_h_total", 32'(h_total), 0);
        check("mid_rst_v_total", 32'(v_total), 0);
        check("mid_rst_probe_rgb", 32'(probe_rgb), 0);
        @(negedge clk);
        reset = 1'b0;
        run_frames(2, "reacq_a");
        check("reacq_not_yet", 32'(locked), 0);
        run_frames(1, "reacq_b");
        check("reacq_locked", 32'(locked), 1);
        check("reacq_v_total", 32'(v_total), VE);

`ifdef VGA_MON_CRC_EN
        g_mode = 1;
        run_frames(1, "sig_one");
        check("frame_sig_one", 32'(frame_sig), 32'h0001);
        g_mode = 2;
        run_frames(1, "sig_zero");
        check("frame_sig_zero", 32'(frame_sig), 32'h0000);
        g_mode = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/vga_sync_monitor.md
Name: vga_sync_monitor

Overview:
- Receive-side counterpart of the VGA timing generator.
- Samples hsync/vsync/rgb on the 25 MHz pixel-tick enable and recovers pixel coordinates.
- Measures line length and frame height, declares lock or error, and captures the rgb value at a programmable probe coordinate.
- Used for on-board self-test: loop the generator output back into it, and read the results over debug/LEDs.

Parameters:
- H_EXPECT, 800, expected pixel ticks per line.
- V_EXPECT, 525, expected lines per frame.
- H_SYNC_POS, 656, x coordinate assigned to the first sample with hsync active.
- V_SYNC_POS, 513, y coordinate assigned to the line in which vsync is first sampled active.
- H_ACTIVE, 640, visible width.
- V_ACTIVE, 480, visible height.
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..15).
- SYNC_ACTIVE, 1, sync polarity (1 = high during retrace).

Ports:
- clk  in  1  100 MHz system clock
- reset  in  1  asynchronous, active-high
- p_tick  in  1  pixel enable, one clk in four
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- rgb  in  12  pixel data
- probe_x  in  10  probe column
- probe_y  in  10  probe row
- err_clr  in  1  clears err, single clk pulse
- rx_x  out  10  recovered column
- rx_y  out  10  recovered row
- rx_active  out  1  rx_x<H_ACTIVE && rx_y<V_ACTIVE
- h_total  out  10  last measured line length
- v_total  out  10  last measured frame height
- locked  out  1  timing matches expected
- err  out  1  sticky mismatch flag
- frame_done  out  1  one-clk pulse per vsync leading edge
- probe_rgb  out  12  captured pixel
- probe_valid  out  1  one-clk pulse on capture

Behaviour:
- All logic is updated only on clk edges where p_tick=1, except the one-clk pulses.
- Reset value of all outputs and state is 0; the FSM resets to IDLE.
- Reset mid-frame aborts everything and requires full reacquisition.
- Edge detect: a leading edge is a sample with sync==SYNC_ACTIVE when the previous sample was not.
- hsync edge:
  - h_total <= h_cnt+1; h_cnt <= 0; rx_x <= H_SYNC_POS.
  - Otherwise rx_x increments, wrapping H_EXPECT-1 -> 0.
  - h_cnt saturates at 1023.
- Line increment: rx_y increments when rx_x wraps to 0, wrapping V_EXPECT-1 -> 0.
- vsync edge:
  - rx_y <= V_SYNC_POS; v_total <= line_cnt; frame_done pulses.
  - line_cnt restarts at 0, or at 1 if an hsync edge occurs in the same sample.
  - Otherwise line_cnt increments on each hsync edge, saturating at 1023.
- Line check:
  - An hsync edge with h_cnt+1 != H_EXPECT marks the frame bad.
  - The first hsync edge after IDLE is not checked.
- FSM:
  - IDLE: wait for a vsync edge -> ACQUIRE, good=0.
  - ACQUIRE: at each vsync edge, if the frame had no bad line and line_cnt==V_EXPECT then good++, else good=0. When good reaches LOCK_FRAMES -> LOCKED.
  - LOCKED: locked=1. A bad line, a v_total mismatch, or h_cnt reaching 1023 (sync loss) -> err=1, locked=0, return to ACQUIRE with good=0. For sync loss (h_cnt reaching 1023), return to IDLE instead.
  - The first vsync edge after IDLE only starts counting.
- err:
  - Set only from LOCKED.
  - Cleared by err_clr.
  - A set and a clear in the same clk: set wins.
- Probe:
  - In LOCKED, on a sample where rx_x==probe_x and rx_y==probe_y: probe_rgb <= rgb and probe_valid pulses for one clk.
  - probe_rgb holds its value otherwise.
  - Probe coordinates beyond H_EXPECT/V_EXPECT never match.
- Latency:
  - rx_x/rx_y describe the current sample; rgb at that sample belongs to those coordinates.
  - All registered outputs update on the clk edge that has p_tick=1.

Optional Feature:
- Macro VGA_MON_CRC_EN.
- When defined:
  - Adds output frame_sig[15:0], reset value 0.
  - Accumulator sig <= {sig[14:0],sig[15]} ^ {4'b0,rgb} on each rx_active sample.
  - At the vsync edge: frame_sig <= sig, then sig <= 0.
  - Accumulates in all FSM states.
- When undefined: the port and logic are absent; all other behaviour is identical.

Test Plan:
- Generator looped back, reset released -> locked=1 at the third vsync edge (IDLE start + 2 good frames); h_total=800, v_total=525, err=0.
- rgb={x[3:0],y[3:0],4'hA}, probe (0,0) -> probe_rgb=12'h00A. Probe (639,479) -> probe_rgb=12'hFFA, with exactly one probe_valid pulse per frame.
- While locked, one line stretched to 801 ticks -> err=1 and locked=0 at that hsync edge; locked=1 again after 2 clean frames; err stays 1 until an err_clr pulse.
- hsync held inactive while locked -> after 1023 p_ticks locked=0, err=1, FSM in IDLE; resuming normal timing relocks.
- Reset asserted mid-line -> all outputs 0 immediately; relock follows the same sequence as the first case.
- VGA_MON_CRC_EN, rgb=0 except pixel (639,479)=12'h001 -> frame_sig=16'h0001. With all rgb=0 -> frame_sig=16'h0000.
